// File: rtl/iob_ram_2p_tiled_clr.sv
// iob_ram_2p_tiled_clr: tiled two-port RAM with byte strobes, hardware clear sequence and optional output register
module iob_ram_2p_tiled_clr_tile #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic                clk,
    input  logic                w_en_i,
    input  logic [DATA_W/8-1:0] w_strb_i,
    input  logic [ADDR_W-1:0]   w_addr_i,
    input  logic [DATA_W-1:0]   w_data_i,
    input  logic                r_en_i,
    input  logic [ADDR_W-1:0]   r_addr_i,
    output logic [DATA_W-1:0]   r_data_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    always_ff @(posedge clk) begin
        for (int k = 0; k < DATA_W / 8; k++)
            if (w_en_i && w_strb_i[k]) mem_q[w_addr_i][8*k+:8] <= w_data_i[8*k+:8];
        if (r_en_i) r_data_o <= mem_q[r_addr_i];
    end
endmodule

module iob_ram_2p_tiled_clr #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 13,
    parameter int TILE_ADDR_W = 11,
    parameter int OUT_REG     = 1
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                clr,
    output logic                busy,
    input  logic                w_en,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic [DATA_W-1:0]   w_data,
    input  logic                r_en,
    input  logic [ADDR_W-1:0]   r_addr,
    output logic [DATA_W-1:0]   r_data,
    output logic                r_valid
);
    localparam int N_TILES = 2 ** (ADDR_W - TILE_ADDR_W);
    localparam int SEL_W = ADDR_W > TILE_ADDR_W ? ADDR_W - TILE_ADDR_W : 1;
    localparam int STRB_W = DATA_W / 8;
    localparam bit OREG = OUT_REG != 0;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic [TILE_ADDR_W-1:0] cnt_q, cnt_d;
    logic                   idle, last, issue, done;
    logic [SEL_W-1:0]       w_sel, r_sel, sel_q;
    logic                   rv0_q, rv1_q, r_valid_q;
    logic [DATA_W-1:0]      tile_rdata [2**SEL_W];
    logic [DATA_W-1:0]      rd_mux, rd1_q, r_data_q;

    assign idle  = state_q == IDLE;
    assign last  = &cnt_q;
    assign issue = r_en && idle;
    assign w_sel = SEL_W'(w_addr >> TILE_ADDR_W);
    assign r_sel = SEL_W'(r_addr >> TILE_ADDR_W);

    always_comb begin
        state_d = idle ? (clr ? CLEAR : IDLE) : (busy_q && last ? IDLE : CLEAR);
        busy_d  = idle ? clr : !(busy_q && last);
        cnt_d   = busy_q ? cnt_q + TILE_ADDR_W'(1) : '0;
    end

    generate
        for (genvar t = 0; t < 2**SEL_W; t++) begin : g_tile
            if (t < N_TILES) begin : g_mem
                iob_ram_2p_tiled_clr_tile #(
                    .DATA_W(DATA_W),
                    .ADDR_W(TILE_ADDR_W)
                ) u_tile (
                    .clk     (clk),
                    .w_en_i  (busy_q || (idle && w_en && w_sel == SEL_W'(t))),
                    .w_strb_i(busy_q ? {STRB_W{1'b1}} : w_strb),
                    .w_addr_i(busy_q ? cnt_q : w_addr[TILE_ADDR_W-1:0]),
                    .w_data_i(busy_q ? '0 : w_data),
                    .r_en_i  (issue && r_sel == SEL_W'(t)),
                    .r_addr_i(r_addr[TILE_ADDR_W-1:0]),
                    .r_data_o(tile_rdata[t])
                );
            end else begin : g_pad
                assign tile_rdata[t] = '0;
            end
        end
    endgenerate

    assign rd_mux = tile_rdata[sel_q];
    assign done   = OREG ? rv1_q : rv0_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= CLEAR;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            sel_q     <= '0;
            rv0_q     <= 1'b0;
            rv1_q     <= 1'b0;
            rd1_q     <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            rv0_q     <= issue;
            rv1_q     <= rv0_q;
            r_valid_q <= done;
            if (issue) sel_q <= r_sel;
            if (rv0_q) rd1_q <= rd_mux;
            if (done) r_data_q <= OREG ? rd1_q : rd_mux;
        end
    end

    assign busy    = busy_q;
    assign r_valid = r_valid_q;
    assign r_data  = r_data_q;
endmodule
